// File: rtl/svi_ser_pkg.sv
// Shared types and defaults for the lane serializer: FSM state encoding and
// the default parallel word width.
package svi_ser_pkg;

    localparam int SER_SIZE_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

endpackage

// File: rtl/svi_shift_lane.sv
// One serializer lane: a SIZE-bit parallel-load shift register whose head bit
// is the serial output. Load wins over shift; vacated positions fill with 0.
module svi_shift_lane #(
    parameter int SIZE      = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            load,
    input  logic            shift,
    input  logic [SIZE-1:0] d,
    output logic            q_bit
);

    logic [SIZE-1:0] sr;
    logic [SIZE-1:0] sr_shifted;

    generate
        if (MSB_FIRST) begin : g_msb
            assign sr_shifted = {sr[SIZE-2:0], 1'b0};
            assign q_bit      = sr[SIZE-1];
        end else begin : g_lsb
            assign sr_shifted = {1'b0, sr[SIZE-1:1]};
            assign q_bit      = sr[0];
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sr <= '0;
        end else if (load) begin
            sr <= d;
        end else if (shift) begin
            sr <= sr_shifted;
        end
    end

endmodule

// File: rtl/svi_lane_serializer.sv
// Captures a pair of SIZE-bit words on a valid/ready handshake and shifts both
// out in lockstep over a two-wire serial port with valid/ready backpressure.
//
//   state | meaning
//   IDLE  | no transfer in flight, ready to accept a word pair
//   SHIFT | serial beats valid; cnt is the index of the beat being presented
module svi_lane_serializer
    import svi_ser_pkg::*;
#(
    parameter int SIZE      = SER_SIZE_DEF,
    parameter bit MSB_FIRST = 1'b0,
    localparam int CNT_W    = $clog2(SIZE)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [SIZE-1:0] i_a,
    input  logic [SIZE-1:0] i_b,
    output logic            o_svalid,
    input  logic            i_sready,
    output logic            o_sa,
    output logic            o_sb,
    output logic            o_last,
    output logic            o_busy
);

    ser_state_e       state;
    ser_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             last_beat;
    logic             lane_load;
    logic             lane_shift;
    logic [1:0]       lane_q;

    assign last_beat = (state == SHIFT) && (cnt == CNT_W'(SIZE - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // o_ready includes i_rst_n so it reads 0 throughout reset and 1 as soon as
    // reset releases; on the last beat it also follows i_sready combinationally.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        o_ready    = 1'b0;
        lane_load  = 1'b0;
        lane_shift = 1'b0;
        case (state)
            IDLE: begin
                o_ready = i_rst_n;
                if (i_valid) begin
                    lane_load = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (i_sready) begin
                    if (!last_beat) begin
                        lane_shift = 1'b1;
                        cnt_nxt    = cnt + CNT_W'(1);
                    end else begin
                        o_ready = i_rst_n;
                        if (i_valid) begin
                            lane_load = 1'b1;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Lane 0 carries word A, lane 1 carries word B.
    svi_shift_lane #(
        .SIZE      (SIZE),
        .MSB_FIRST (MSB_FIRST)
    ) u_lane[1:0] (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .load    (lane_load),
        .shift   (lane_shift),
        .d       ({i_b, i_a}),
        .q_bit   (lane_q)
    );

    assign o_svalid = (state == SHIFT);
    assign o_busy   = (state == SHIFT);
    assign o_last   = last_beat;
    assign o_sa     = lane_q[0];
    assign o_sb     = lane_q[1];

endmodule
